// File: rtl/pid_pkg.sv
// Shared definitions for the PID position controller.
// Holds the control-mode codes, the FSM state encoding and the internal
// datapath widths used by pid_control and pid_mac.
package pid_pkg;

   localparam int DATA_W = 24;   // external data width (setpoint, gains, duty)
   localparam int ERR_W  = 25;   // setpoint - position without overflow
   localparam int INT_W  = 32;   // integral accumulator / MAC B operand
   localparam int ACC_W  = 64;   // PID sum accumulator

   localparam logic [7:0] MODE_POSITION = 8'd0;
   localparam logic [7:0] MODE_DIRECT   = 8'd1;

   // Largest positive value representable on the 24-bit duty output.
   localparam logic [DATA_W-1:0] DUTY_POS_MAX = 24'd8388607;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ERR   = 3'd1,
      S_MUL_P = 3'd2,
      S_MUL_I = 3'd3,
      S_MUL_D = 3'd4,
      S_SAT   = 3'd5
   } pid_state_e;

endpackage

// File: rtl/pid_mac.sv
// Signed multiply-accumulate shared by the three PID terms.
// Ports:
//   CLK, reset   clock / asynchronous active-high reset (clears accumulator)
//   i_clear      synchronous clear of the accumulator (wins over i_en)
//   i_en         add i_a * i_b to the accumulator this cycle
//   i_a          24-bit signed gain operand
//   i_b          32-bit signed error / integral / derivative operand
//   o_acc        64-bit signed accumulator
module pid_mac
   import pid_pkg::*;
(
   input  logic                     CLK,
   input  logic                     reset,
   input  logic                     i_clear,
   input  logic                     i_en,
   input  logic signed [DATA_W-1:0] i_a,
   input  logic signed [INT_W-1:0]  i_b,
   output logic signed [ACC_W-1:0]  o_acc
);

   localparam int PROD_W = DATA_W + INT_W;

   logic signed [PROD_W-1:0] w_a_ext;
   logic signed [PROD_W-1:0] w_b_ext;
   logic signed [PROD_W-1:0] w_prod;
   logic signed [ACC_W-1:0]  w_prod_ext;
   logic signed [ACC_W-1:0]  r_acc;

   // Both operands are widened to the full product width so the multiply is
   // carried out at 56 bits with no truncation of the true product.
   assign w_a_ext    = {{INT_W{i_a[DATA_W-1]}}, i_a};
   assign w_b_ext    = {{DATA_W{i_b[INT_W-1]}}, i_b};
   assign w_prod     = w_a_ext * w_b_ext;
   assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_acc <= '0;
      end else if (i_clear) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= r_acc + w_prod_ext;
      end
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/pid_control.sv
// PID position controller with a single time-shared MAC.
// A tick in IDLE starts ERR -> MUL_P -> MUL_I -> MUL_D -> SAT; duty is
// written in SAT and duty_valid pulses in the following cycle (tick + 5).
// Ports:
//   CLK, reset           clock / asynchronous active-high reset
//   update_tick          control-loop strobe (ignored while busy)
//   control_mode         0 position PID, 1 direct duty, other off
//   setpoint, position   24-bit signed target / measured position
//   Kp, Ki, Kd           24-bit signed gains
//   PWMLimit             24-bit unsigned symmetric duty limit
//   IntegralLimit        24-bit unsigned symmetric integral limit
//   deadband             24-bit unsigned error deadband
//   duty                 registered 24-bit signed PWM command
//   duty_valid           one-cycle pulse when duty is written
//   busy                 computation in progress (ERR..SAT)
//   overrun              tick arrived while busy (same cycle)
module pid_control
   import pid_pkg::*;
#(
   parameter int OUT_SHIFT = 0
) (
   input  logic                     CLK,
   input  logic                     reset,
   input  logic                     update_tick,
   input  logic [7:0]               control_mode,
   input  logic signed [DATA_W-1:0] setpoint,
   input  logic signed [DATA_W-1:0] position,
   input  logic signed [DATA_W-1:0] Kp,
   input  logic signed [DATA_W-1:0] Ki,
   input  logic signed [DATA_W-1:0] Kd,
   input  logic [DATA_W-1:0]        PWMLimit,
   input  logic [DATA_W-1:0]        IntegralLimit,
   input  logic [DATA_W-1:0]        deadband,
   output logic signed [DATA_W-1:0] duty,
   output logic                     duty_valid,
   output logic                     busy,
   output logic                     overrun
);

   pid_state_e r_state;
   pid_state_e w_state_nxt;

   // Operands captured in ERR so later input changes cannot leak in.
   logic [7:0]               r_mode;
   logic signed [DATA_W-1:0] r_kp;
   logic signed [DATA_W-1:0] r_ki;
   logic signed [DATA_W-1:0] r_kd;
   logic signed [DATA_W-1:0] r_setpoint;
   logic [DATA_W-1:0]        r_pwm_lim;
   logic signed [ERR_W-1:0]  r_err_eff;
   logic signed [INT_W-1:0]  r_deriv;

   logic signed [ERR_W-1:0]  r_err_prev;
   logic signed [INT_W-1:0]  r_integral;
   logic signed [DATA_W-1:0] r_duty;
   logic                     r_duty_valid;

   logic signed [ERR_W-1:0]  w_err;
   logic [ERR_W-1:0]         w_err_abs;
   logic signed [ERR_W-1:0]  w_err_eff;
   logic signed [INT_W:0]    w_int_sum;
   logic signed [INT_W-1:0]  w_int_nxt;
   logic signed [INT_W-1:0]  w_deriv;
   logic [DATA_W-1:0]        w_pwm_cap;
   logic signed [ACC_W-1:0]  w_acc;
   logic signed [ACC_W-1:0]  w_acc_shr;
   logic signed [DATA_W-1:0] w_duty_nxt;

   logic                     w_mac_clear;
   logic                     w_mac_en;
   logic signed [DATA_W-1:0] w_mac_a;
   logic signed [INT_W-1:0]  w_mac_b;

   // Symmetric clamp of the widened integral sum to +/-lim.
   function automatic logic signed [INT_W-1:0] sat_integral(
      input logic signed [INT_W:0] v,
      input logic [DATA_W-1:0]     lim
   );
      logic signed [INT_W:0] l_pos;
      logic signed [INT_W:0] l_neg;
      logic signed [INT_W:0] l_res;
      l_pos = {{(INT_W+1-DATA_W){1'b0}}, lim};
      l_neg = -l_pos;
      if (v > l_pos)      l_res = l_pos;
      else if (v < l_neg) l_res = l_neg;
      else                l_res = v;
      return l_res[INT_W-1:0];
   endfunction

   // Symmetric clamp of a 64-bit value onto the 24-bit duty range +/-lim.
   function automatic logic signed [DATA_W-1:0] sat_duty(
      input logic signed [ACC_W-1:0] v,
      input logic [DATA_W-1:0]       lim
   );
      logic signed [ACC_W-1:0] l_pos;
      logic signed [ACC_W-1:0] l_neg;
      logic signed [ACC_W-1:0] l_res;
      l_pos = {{(ACC_W-DATA_W){1'b0}}, lim};
      l_neg = -l_pos;
      if (v > l_pos)      l_res = l_pos;
      else if (v < l_neg) l_res = l_neg;
      else                l_res = v;
      return l_res[DATA_W-1:0];
   endfunction

   // Error path, evaluated against the live inputs during ERR.
   assign w_err     = {setpoint[DATA_W-1], setpoint} - {position[DATA_W-1], position};
   assign w_err_abs = w_err[ERR_W-1] ? -w_err : w_err;
   assign w_err_eff = (w_err_abs <= {1'b0, deadband}) ? '0 : w_err;
   assign w_int_sum = {r_integral[INT_W-1], r_integral}
                    + {{(INT_W+1-ERR_W){w_err_eff[ERR_W-1]}}, w_err_eff};
   assign w_int_nxt = sat_integral(w_int_sum, IntegralLimit);
   assign w_deriv   = {{(INT_W-ERR_W){w_err_eff[ERR_W-1]}}, w_err_eff}
                    - {{(INT_W-ERR_W){r_err_prev[ERR_W-1]}}, r_err_prev};

   // Output path, evaluated from captured operands during SAT.
   assign w_pwm_cap = (r_pwm_lim > DUTY_POS_MAX) ? DUTY_POS_MAX : r_pwm_lim;
   assign w_acc_shr = w_acc >>> OUT_SHIFT;

   always_comb begin
      w_duty_nxt = '0;
      case (r_mode)
         MODE_POSITION: w_duty_nxt = sat_duty(w_acc_shr, w_pwm_cap);
         MODE_DIRECT:   w_duty_nxt = sat_duty({{(ACC_W-DATA_W){r_setpoint[DATA_W-1]}}, r_setpoint},
                                              r_pwm_lim);
         default:       w_duty_nxt = '0;
      endcase
   end

   // FSM
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (update_tick) w_state_nxt = S_ERR;
         S_ERR:   w_state_nxt = S_MUL_P;
         S_MUL_P: w_state_nxt = S_MUL_I;
         S_MUL_I: w_state_nxt = S_MUL_D;
         S_MUL_D: w_state_nxt = S_SAT;
         S_SAT:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // MAC operand selection: one product per MUL state, only in position mode.
   always_comb begin
      w_mac_clear = (r_state == S_ERR);
      w_mac_en    = 1'b0;
      w_mac_a     = '0;
      w_mac_b     = '0;
      case (r_state)
         S_MUL_P: begin
            w_mac_en = (r_mode == MODE_POSITION);
            w_mac_a  = r_kp;
            w_mac_b  = {{(INT_W-ERR_W){r_err_eff[ERR_W-1]}}, r_err_eff};
         end
         S_MUL_I: begin
            w_mac_en = (r_mode == MODE_POSITION);
            w_mac_a  = r_ki;
            w_mac_b  = r_integral;
         end
         S_MUL_D: begin
            w_mac_en = (r_mode == MODE_POSITION);
            w_mac_a  = r_kd;
            w_mac_b  = r_deriv;
         end
         default: ;
      endcase
   end

   pid_mac u_mac (
      .CLK     (CLK),
      .reset   (reset),
      .i_clear (w_mac_clear),
      .i_en    (w_mac_en),
      .i_a     (w_mac_a),
      .i_b     (w_mac_b),
      .o_acc   (w_acc)
   );

   // Operand capture: pure data, no reset needed.
   always_ff @(posedge CLK) begin
      if (r_state == S_ERR) begin
         r_mode     <= control_mode;
         r_kp       <= Kp;
         r_ki       <= Ki;
         r_kd       <= Kd;
         r_setpoint <= setpoint;
         r_pwm_lim  <= PWMLimit;
         r_err_eff  <= w_err_eff;
         r_deriv    <= w_deriv;
      end
   end

   // Loop state and output registers.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_integral   <= '0;
         r_err_prev   <= '0;
         r_duty       <= '0;
         r_duty_valid <= 1'b0;
      end else begin
         r_duty_valid <= 1'b0;
         if (r_state == S_ERR) begin
            if (control_mode == MODE_POSITION) begin
               r_integral <= w_int_nxt;
               r_err_prev <= w_err_eff;
            end else begin
               // Leaving position mode drops loop history so re-entry is bumpless.
               r_integral <= '0;
               r_err_prev <= '0;
            end
         end
         if (r_state == S_SAT) begin
            r_duty       <= w_duty_nxt;
            r_duty_valid <= 1'b1;
         end
      end
   end

   assign duty       = r_duty;
   assign duty_valid = r_duty_valid;
   assign busy       = (r_state != S_IDLE);
   assign overrun    = update_tick & busy;

endmodule

// File: tb/tb_pid_control.sv
// Self-checking bench for pid_control: directed scenarios plus randomized
// ticks compared against an arithmetic reference model of the control law.
module tb_pid_control;

   localparam int OUT_SHIFT = 0;

   logic               CLK = 1'b0;
   logic               reset = 1'b1;
   logic               update_tick = 1'b0;
   logic [7:0]         control_mode = '0;
   logic signed [23:0] setpoint = '0;
   logic signed [23:0] position = '0;
   logic signed [23:0] Kp = '0;
   logic signed [23:0] Ki = '0;
   logic signed [23:0] Kd = '0;
   logic [23:0]        PWMLimit = '0;
   logic [23:0]        IntegralLimit = '0;
   logic [23:0]        deadband = '0;
   logic signed [23:0] duty;
   logic               duty_valid;
   logic               busy;
   logic               overrun;

   int checks = 0;
   int errors = 0;

   // Reference model state
   longint m_int  = 0;
   longint m_prev = 0;

   pid_control #(.OUT_SHIFT(OUT_SHIFT)) dut (
      .CLK           (CLK),
      .reset         (reset),
      .update_tick   (update_tick),
      .control_mode  (control_mode),
      .setpoint      (setpoint),
      .position      (position),
      .Kp            (Kp),
      .Ki            (Ki),
      .Kd            (Kd),
      .PWMLimit      (PWMLimit),
      .IntegralLimit (IntegralLimit),
      .deadband      (deadband),
      .duty          (duty),
      .duty_valid    (duty_valid),
      .busy          (busy),
      .overrun       (overrun)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint clampl(input longint v, input longint lim);
      if (v > lim)  return lim;
      if (v < -lim) return -lim;
      return v;
   endfunction

   // One control-loop update in terms of the documented law.
   task automatic model_step(input int mode, input int sp, input int pos,
                             input int kp, input int ki, input int kd,
                             input int pwm, input int ilim, input int db,
                             output longint exp);
      longint err, eff, deriv, sum, lim;
      if (mode == 0) begin
         err    = longint'(sp) - longint'(pos);
         eff    = (((err < 0) ? -err : err) <= longint'(db)) ? 0 : err;
         m_int  = clampl(m_int + eff, longint'(ilim));
         deriv  = eff - m_prev;
         m_prev = eff;
         sum    = longint'(kp) * eff + longint'(ki) * m_int + longint'(kd) * deriv;
         sum    = sum >>> OUT_SHIFT;
         lim    = (pwm > 8388607) ? 64'sd8388607 : longint'(pwm);
         exp    = clampl(sum, lim);
      end else begin
         m_int  = 0;
         m_prev = 0;
         exp    = (mode == 1) ? clampl(longint'(sp), longint'(pwm)) : 0;
      end
   endtask

   task automatic scramble_inputs();
      control_mode  = 8'($urandom);
      setpoint      = 24'($urandom);
      position      = 24'($urandom);
      Kp            = 24'($urandom);
      Ki            = 24'($urandom);
      Kd            = 24'($urandom);
      PWMLimit      = 24'($urandom);
      IntegralLimit = 24'($urandom);
      deadband      = 24'($urandom);
   endtask

   // Caller positions us just after a falling edge. Drives one tick, checks
   // busy over the computation, the N+5 latency and the duty value.
   task automatic run_tick(input string tag, input int mode, input int sp, input int pos,
                           input int kp, input int ki, input int kd,
                           input int pwm, input int ilim, input int db,
                           output longint got);
      longint exp;
      int     lat;
      bit     busy_ok;
      control_mode  = 8'(mode);
      setpoint      = 24'(sp);
      position      = 24'(pos);
      Kp            = 24'(kp);
      Ki            = 24'(ki);
      Kd            = 24'(kd);
      PWMLimit      = 24'(pwm);
      IntegralLimit = 24'(ilim);
      deadband      = 24'(db);
      update_tick   = 1'b1;
      model_step(mode, sp, pos, kp, ki, kd, pwm, ilim, db, exp);
      @(posedge CLK); #1;
      busy_ok = (busy === 1'b1);
      @(negedge CLK);
      update_tick = 1'b0;
      lat = 99;
      got = 0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge CLK); #1;
         if (k == 1) scramble_inputs();
         if (duty_valid === 1'b1) begin
            lat = k;
            got = longint'(duty);
            if (busy !== 1'b0) busy_ok = 1'b0;
            break;
         end
         if (busy !== 1'b1) busy_ok = 1'b0;
      end
      check({tag, "_latency"}, longint'(lat), 5);
      check({tag, "_duty"}, got, exp);
      check({tag, "_busy"}, longint'(busy_ok), 1);
   endtask

   initial begin
      longint got;
      longint exp;
      int     cnt;

      // Reset state
      #1;
      check("rst_duty", longint'(duty), 0);
      check("rst_valid", longint'(duty_valid), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_overrun", longint'(overrun), 0);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      reset = 1'b0;

      // P-only, tick in the first cycle after reset release
      run_tick("p_only", 0, 100, 0, 10, 0, 0, 8388607, 0, 0, got);
      check("p_only_const", got, 1000);

      // Saturation
      @(negedge CLK);
      run_tick("sat_pos", 0, 1000000, 0, 100, 0, 0, 5000, 0, 0, got);
      check("sat_pos_const", got, 5000);
      @(negedge CLK);
      run_tick("sat_neg", 0, -1000000, 0, 100, 0, 0, 5000, 0, 0, got);
      check("sat_neg_const", got, -5000);

      // Integral windup
      @(negedge CLK);
      run_tick("wind1", 0, 1000, 0, 0, 1, 0, 8388607, 2500, 0, got);
      check("wind1_const", got, 1000);
      @(negedge CLK);
      run_tick("wind2", 0, 1000, 0, 0, 1, 0, 8388607, 2500, 0, got);
      check("wind2_const", got, 2000);
      @(negedge CLK);
      run_tick("wind3", 0, 1000, 0, 0, 1, 0, 8388607, 2500, 0, got);
      check("wind3_const", got, 2500);
      @(negedge CLK);
      run_tick("wind4", 0, 1000, 0, 0, 1, 0, 8388607, 2500, 0, got);
      check("wind4_const", got, 2500);

      // Deadband, then confirm the integral was left alone
      @(negedge CLK);
      run_tick("dband", 0, 40, 0, 1, 0, 0, 8388607, 2500, 50, got);
      check("dband_const", got, 0);
      @(negedge CLK);
      run_tick("dband_int", 0, 0, 0, 0, 1, 0, 8388607, 2500, 50, got);
      check("dband_int_const", got, 2500);

      // Derivative
      @(negedge CLK);
      run_tick("deriv1", 0, 100, 0, 0, 0, 2, 8388607, 2500, 0, got);
      check("deriv1_const", got, 200);
      @(negedge CLK);
      run_tick("deriv2", 0, 150, 0, 0, 0, 2, 8388607, 2500, 0, got);
      check("deriv2_const", got, 100);

      // Direct and off modes
      @(negedge CLK);
      run_tick("direct", 1, -300, 0, 0, 0, 0, 200, 2500, 0, got);
      check("direct_const", got, -200);
      @(negedge CLK);
      run_tick("off", 7, 1234, 0, 5, 5, 5, 200, 2500, 0, got);
      check("off_const", got, 0);

      // PWMLimit of zero
      @(negedge CLK);
      run_tick("pwm0", 0, 100, 0, 10, 0, 0, 0, 0, 0, got);
      check("pwm0_const", got, 0);

      // Overrun: second tick two cycles after the first
      @(negedge CLK);
      control_mode = 8'd0; setpoint = 24'sd500; position = 24'sd100;
      Kp = 24'sd3; Ki = '0; Kd = '0; PWMLimit = 24'd8388607;
      IntegralLimit = '0; deadband = '0;
      update_tick = 1'b1;
      model_step(0, 500, 100, 3, 0, 0, 8388607, 0, 0, exp);
      @(posedge CLK);
      @(negedge CLK); update_tick = 1'b0;
      @(negedge CLK); update_tick = 1'b1;
      #1;
      check("ovr_pulse", longint'(overrun), 1);
      @(negedge CLK); update_tick = 1'b0;
      #1;
      check("ovr_clear", longint'(overrun), 0);
      cnt = 0;
      got = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge CLK); #1;
         if (duty_valid === 1'b1) begin
            cnt++;
            got = longint'(duty);
         end
      end
      check("ovr_valid_count", longint'(cnt), 1);
      check("ovr_duty", got, exp);
      check("ovr_duty_const", got, 1200);

      // Reset asserted while in MUL_I
      @(negedge CLK);
      control_mode = 8'd0; setpoint = 24'sd1000; position = '0;
      Kp = 24'sd7; Ki = 24'sd1; Kd = '0; PWMLimit = 24'd8388607;
      IntegralLimit = 24'd100000; deadband = '0;
      update_tick = 1'b1;
      @(posedge CLK);
      @(negedge CLK); update_tick = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      #2 reset = 1'b1;
      #1;
      check("midrst_duty", longint'(duty), 0);
      check("midrst_busy", longint'(busy), 0);
      check("midrst_valid", longint'(duty_valid), 0);
      m_int  = 0;
      m_prev = 0;
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge CLK); #1;
         if (duty_valid === 1'b1) cnt++;
      end
      check("midrst_no_valid", longint'(cnt), 0);
      @(negedge CLK);
      reset = 1'b0;
      run_tick("post_rst", 0, 300, 0, 0, 1, 0, 8388607, 100000, 0, got);
      check("post_rst_const", got, 300);

      // Randomized updates against the reference model
      for (int n = 0; n < 24; n++) begin
         int mode, sp, pos, kp, ki, kd, pwm, ilim, db, sel;
         sel  = int'($urandom_range(0, 9));
         mode = (sel == 0) ? 1 : ((sel == 1) ? int'($urandom_range(2, 255)) : 0);
         sp   = int'($urandom_range(0, 2097152)) - 1048576;
         pos  = int'($urandom_range(0, 2097152)) - 1048576;
         kp   = int'($urandom_range(0, 2000)) - 1000;
         ki   = int'($urandom_range(0, 100)) - 50;
         kd   = int'($urandom_range(0, 400)) - 200;
         pwm  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16777215))
                                            : int'($urandom_range(0, 100000));
         ilim = int'($urandom_range(0, 200000));
         db   = int'($urandom_range(0, 200));
         @(negedge CLK);
         run_tick("rand", mode, sp, pos, kp, ki, kd, pwm, ilim, db, got);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pid_control.md
PID_CONTROL -- requirements
Module: pid_control

Interface
REQ-001 SHALL have parameter OUT_SHIFT, default 0, arithmetic right shift applied to the PID sum before clamping.
REQ-002 SHALL have CLK  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have reset  in  1  asynchronous, active-high.
REQ-004 SHALL have update_tick  in  1  single-cycle control-loop strobe.
REQ-005 SHALL have control_mode  in  8  0 = position PID, 1 = direct PWM, other = off.
REQ-006 SHALL have setpoint  in  24 signed  target position (mode 0) or raw duty (mode 1).
REQ-007 SHALL have position  in  24 signed  measured encoder position.
REQ-008 SHALL have Kp, Ki, Kd  in  24 signed each  gains.
REQ-009 SHALL have PWMLimit, IntegralLimit, deadband  in  24 unsigned each  limits.
REQ-010 SHALL have duty  out  24 signed  registered PWM command.
REQ-011 SHALL have duty_valid  out  1  one-cycle pulse when duty updates.
REQ-012 SHALL have busy  out  1  high while a computation is in progress.
REQ-013 SHALL have overrun  out  1  one-cycle pulse when update_tick arrives while busy.

Function
REQ-014 SHALL implement FSM IDLE -> ERR -> MUL_P -> MUL_I -> MUL_D -> SAT -> IDLE, one state per cycle.
REQ-015 SHALL leave IDLE only on update_tick; tick sampled at cycle N gives duty and duty_valid high at cycle N+5.
REQ-016 SHALL ignore update_tick while busy and pulse overrun in that cycle; the computation in progress is not disturbed.
REQ-017 SHALL sample all inputs in the ERR cycle; later input changes do not affect the current result.
REQ-018 SHALL compute err = setpoint - position in 25-bit signed arithmetic.
REQ-019 SHALL force err_eff = 0 when |err| <= deadband, else err_eff = err.
REQ-020 SHALL update a 32-bit signed integral as integral + err_eff, then clamp to +/-IntegralLimit.
REQ-021 SHALL compute deriv = err_eff - err_prev, then store err_prev <= err_eff.
REQ-022 SHALL accumulate sum = Kp*err_eff + Ki*integral + Kd*deriv in a 64-bit signed accumulator, one product per MUL state.
REQ-023 SHALL compute sum >>> OUT_SHIFT, clamp to +/-min(PWMLimit, 8388607), and write the result to duty in SAT.
REQ-024 SHALL set duty = 0 when PWMLimit = 0.
REQ-025 SHALL, in mode 1, clamp setpoint to +/-PWMLimit as duty, clear integral and err_prev, and keep the same N+5 latency.
REQ-026 SHALL, in any other mode, set duty = 0, clear integral and err_prev, and keep the same latency.
REQ-027 SHALL raise busy from the cycle after the tick through the SAT cycle inclusive.

Reset
REQ-028 SHALL on reset, at any point including mid-computation, set FSM = IDLE, duty = 0, duty_valid = 0, busy = 0, overrun = 0, integral = 0, err_prev = 0, accumulator = 0.
REQ-029 SHALL accept the first update_tick in the first cycle after reset deasserts.

Structure
REQ-030 SHALL place the mode codes (MODE_POSITION = 0, MODE_DIRECT = 1), the FSM state encoding, and the widths (ERR_W = 25, INT_W = 32, ACC_W = 64) in the shared package pid_pkg.
REQ-031 SHALL use a single time-shared signed multiply-accumulate sub-module pid_mac (24x32 multiply into the 64-bit accumulator, with clear and enable inputs).

Verification
REQ-032 SHALL cover P-only: mode 0, setpoint 100, position 0, Kp 10, Ki = Kd = 0, PWMLimit 8388607, tick -> duty 1000, with duty_valid exactly 5 cycles after the tick.
REQ-033 SHALL cover saturation: Kp 100, err +1000000 then -1000000, PWMLimit 5000 -> duty 5000, then -5000.
REQ-034 SHALL cover windup: Kp 0, Ki 1, err 1000, IntegralLimit 2500, four ticks -> duty 1000, 2000, 2500, 2500.
REQ-035 SHALL cover deadband and derivative: deadband 50, Kp 1, err 40 -> duty 0 with integral unchanged; then Kp 0, Kd 2, deadband 0, err 100 then 150 -> duty 200, then 100.
REQ-036 SHALL cover direct mode: mode 1, setpoint -300, PWMLimit 200 -> duty -200; mode 7 -> duty 0.
REQ-037 SHALL cover overrun and reset: a second tick 2 cycles after the first -> overrun pulse and exactly one duty_valid; reset asserted in MUL_I -> duty 0, busy 0, and no duty_valid.
